// File: rtl/exe_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU opcodes, forward selects, multiplier FSM states.
package exe_pkg;

    localparam logic [2:0] ALU_SUB = 3'b000;
    localparam logic [2:0] ALU_MUL = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;
    localparam logic [2:0] ALU_ADD = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative radix-2^MUL_BITS multiplier returning the low DATA_W bits of the product.
// Low product bits are identical for signed and unsigned operands, so an unsigned shift-add suffices.
module exe_mul_iter
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MUL_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);

    localparam int unsigned N     = DATA_W / MUL_BITS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    mul_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_a, r_b, r_acc;
    logic [DATA_W-1:0] w_a_nxt, w_b_nxt, w_acc_nxt;
    logic [DATA_W-1:0] w_digit;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_busy, r_done;

    assign w_digit   = DATA_W'(r_b[MUL_BITS-1:0]);
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

    // Next-state and datapath step: one MUL_BITS digit of B retired per BUSY cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_BUSY;
                    w_a_nxt     = i_op_a;
                    w_b_nxt     = i_op_b;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = CNT_W'(N - 1);
                end
            end
            ST_BUSY: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_acc_nxt = r_acc + (r_a * w_digit);
                    w_a_nxt   = r_a << MUL_BITS;
                    w_b_nxt   = r_b >> MUL_BITS;
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_BUSY);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding muxes, ALU, branch resolution, iterative multiply with stall, EX/MEM register.
module execute_stage_mc
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 6,
    parameter int unsigned MUL_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_e,
    input  logic                  flush_e,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic                  ResultSrcE,
    input  logic                  BranchE,
    input  logic                  ALUSrcE,
    input  logic [2:0]            ALUControlE,
    input  logic [DATA_W-1:0]     RD1_E,
    input  logic [DATA_W-1:0]     RD2_E,
    input  logic [DATA_W-1:0]     Imm_Ext_E,
    input  logic [DATA_W-1:0]     PCE,
    input  logic [DATA_W-1:0]     PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [DATA_W-1:0]     ResultW,
    input  logic [1:0]            ForwardA_E,
    input  logic [1:0]            ForwardB_E,
    output logic                  stall_e,
    output logic                  PCSrcE,
    output logic [DATA_W-1:0]     PCTargetE,
    output logic                  valid_m,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [DATA_W-1:0]     ALU_ResultM,
    output logic [DATA_W-1:0]     WriteDataM,
    output logic [DATA_W-1:0]     PCPlus4M
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] w_src_a, w_src_b, w_write_data;
    logic [DATA_W-1:0] w_alu_res, w_sub, w_result, w_product;
    logic [SH_W-1:0]   w_shamt;
    logic              w_live, w_issue, w_load;
    logic              w_mul_busy, w_mul_done;

    always_comb begin
        case (ForwardA_E)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = ALU_ResultM;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardB_E)
            FWD_WB:  w_write_data = ResultW;
            FWD_MEM: w_write_data = ALU_ResultM;
            default: w_write_data = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_write_data;
    assign w_shamt = w_src_b[SH_W-1:0];
    assign w_sub   = w_src_a - w_src_b;

    always_comb begin
        case (ALUControlE)
            ALU_SUB: w_alu_res = w_sub;
            ALU_OR:  w_alu_res = w_src_a | w_src_b;
            ALU_SRL: w_alu_res = w_src_a >> w_shamt;
            ALU_AND: w_alu_res = w_src_a & w_src_b;
            ALU_SLL: w_alu_res = w_src_a << w_shamt;
            ALU_SRA: w_alu_res = DATA_W'($signed(w_src_a) >>> w_shamt);
            ALU_ADD: w_alu_res = w_src_a + w_src_b;
            default: w_alu_res = '0;
        endcase
    end

    exe_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_issue),
        .i_abort   (flush_e),
        .i_op_a    (w_src_a),
        .i_op_b    (w_src_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // DONE does not re-decode the op, so a held multiply cannot restart itself.
    assign w_live    = valid_e & ~flush_e;
    assign w_issue   = w_live & (ALUControlE == ALU_MUL) & ~w_mul_busy & ~w_mul_done;
    assign stall_e   = rst & (w_issue | w_mul_busy);
    assign PCSrcE    = rst & w_live & BranchE & (w_sub == '0) & ~w_mul_busy;
    assign PCTargetE = PCE + Imm_Ext_E;

    assign w_load   = w_mul_done ? ~flush_e
                                 : (~w_mul_busy & w_live & (ALUControlE != ALU_MUL));
    assign w_result = w_mul_done ? w_product : w_alu_res;

    // EX/MEM register: a bubble clears the valid/write strobes and holds the data fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_m     <= 1'b0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            ALU_ResultM <= '0;
            WriteDataM  <= '0;
            PCPlus4M    <= '0;
        end else begin
            valid_m   <= w_load;
            RegWriteM <= w_load & RegWriteE;
            MemWriteM <= w_load & MemWriteE;
            if (w_load) begin
                ResultSrcM  <= ResultSrcE;
                RD_M        <= RD_E;
                ALU_ResultM <= w_result;
                WriteDataM  <= w_write_data;
                PCPlus4M    <= PCPlus4E;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed self-checking bench for execute_stage_mc (DATA_W=32, MUL_BITS=2, so N=16).
module tb_execute_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e, flush_e, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [5:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        stall_e, PCSrcE, valid_m, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
    logic [5:0]  RD_M;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_stage_mc #(.DATA_W(32), .REG_ADDR_W(6), .MUL_BITS(2)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .stall_e(stall_e), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .valid_m(valid_m), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_e = 0; flush_e = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; ALUSrcE = 0; ALUControlE = 3'b111; RD1_E = 0; RD2_E = 0;
        Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0; ResultW = 0;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    // Presents a multiply until the DONE edge; reports stall length and non-bubble cycles seen.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] late_a,
                           output int cyc, output int leaks);
        valid_e = 1; flush_e = 0; ALUControlE = 3'b001; ALUSrcE = 0; BranchE = 0;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; RD1_E = a; RD2_E = b;
        RegWriteE = 1; MemWriteE = 0; RD_E = 6'd7;
        cyc = 0; leaks = 0;
        #1;
        while (stall_e === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
            RD1_E = late_a;
            #1;
            if (valid_m !== 1'b0) leaks++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        valid_e = 1; BranchE = 1; ALUControlE = 3'b001;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (stall_e !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_e); end
        n_checks++; if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL reset_pcsrc: got %b expected 0", PCSrcE); end
        n_checks++; if ({valid_m, RegWriteM, MemWriteM, ResultSrcM} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {valid_m, RegWriteM, MemWriteM, ResultSrcM}); end
        n_checks++; if ({ALU_ResultM, WriteDataM, PCPlus4M, RD_M} !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h expected zeros", ALU_ResultM, WriteDataM, PCPlus4M, RD_M); end
        idle_inputs();
        rst = 1;
        tick();
    endtask

    task automatic test_alu();
        logic [2:0]  t_op [10] = '{3'b000, 3'b110, 3'b011, 3'b101, 3'b101, 3'b100, 3'b010, 3'b111, 3'b110, 3'b110};
        logic [31:0] t_a  [10] = '{32'h0, 32'h80000000, 32'h80000000, 32'h1, 32'h5, 32'hF0F00000, 32'hF0F00000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFF0};
        logic [31:0] t_b  [10] = '{32'h5, 32'h4, 32'h4, 32'd31, 32'd32, 32'hFF00FF00, 32'hFF00FF00, 32'h1, 32'd31, 32'd4};
        logic [31:0] t_r  [10] = '{32'hFFFFFFFB, 32'hF8000000, 32'h08000000, 32'h80000000, 32'h5, 32'hF0000000, 32'hFFF0FF00, 32'h0, 32'hFFFFFFFF, 32'h07FFFFFF};
        idle_inputs();
        valid_e = 1; RegWriteE = 1; ResultSrcE = 1; RD_E = 6'd5; PCPlus4E = 32'h104;
        RD1_E = 3; Imm_Ext_E = 7; ALUSrcE = 1; ALUControlE = 3'b111;
        tick();
        n_checks++; if (ALU_ResultM !== 32'h0000000A) begin n_fail++; $display("FAIL add_imm_result: got %h expected 0000000a", ALU_ResultM); end
        n_checks++; if ({valid_m, RegWriteM, ResultSrcM} !== 3'b111) begin n_fail++; $display("FAIL add_imm_ctrl: got %b expected 111", {valid_m, RegWriteM, ResultSrcM}); end
        n_checks++; if (RD_M !== 6'd5 || PCPlus4M !== 32'h104) begin n_fail++; $display("FAIL add_imm_fields: got rd %0d pc4 %h expected 5 00000104", RD_M, PCPlus4M); end
        ALUSrcE = 0;
        for (int i = 0; i < 10; i++) begin
            ALUControlE = t_op[i]; RD1_E = t_a[i]; RD2_E = t_b[i];
            tick();
            n_checks++; if (ALU_ResultM !== t_r[i] || valid_m !== 1'b1) begin n_fail++; $display("FAIL alu_vec%0d: got %h v%b expected %h v1", i, ALU_ResultM, valid_m, t_r[i]); end
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        valid_e = 1; RegWriteE = 1; RD1_E = 32'h10; ALUSrcE = 1; ALUControlE = 3'b111;
        tick();
        ForwardA_E = 2'b10; RD1_E = 32'hDEAD; RD2_E = 1; ALUSrcE = 0;
        tick();
        n_checks++; if (ALU_ResultM !== 32'h11) begin n_fail++; $display("FAIL fwd_a_mem: got %h expected 00000011", ALU_ResultM); end
        ForwardA_E = 2'b00; ForwardB_E = 2'b01; ResultW = 2; RD1_E = 0; RD2_E = 99; MemWriteE = 1;
        tick();
        n_checks++; if (WriteDataM !== 32'h2 || ALU_ResultM !== 32'h2 || MemWriteM !== 1'b1) begin n_fail++; $display("FAIL fwd_b_wb: got wd %h res %h mw %b expected 2 2 1", WriteDataM, ALU_ResultM, MemWriteM); end
        ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 7; RD2_E = 1; ResultW = 100; MemWriteE = 0;
        tick();
        n_checks++; if (ALU_ResultM !== 32'h8 || WriteDataM !== 32'h1) begin n_fail++; $display("FAIL fwd_11_regfile: got res %h wd %h expected 8 1", ALU_ResultM, WriteDataM); end
        ForwardA_E = 2'b01; ForwardB_E = 2'b00; ResultW = 32'h20; RD1_E = 0; RD2_E = 3; ALUControlE = 3'b000;
        tick();
        n_checks++; if (ALU_ResultM !== 32'h1D) begin n_fail++; $display("FAIL fwd_a_wb_sub: got %h expected 0000001d", ALU_ResultM); end
    endtask

    task automatic test_branch();
        idle_inputs();
        valid_e = 1; BranchE = 1; RD1_E = 5; RD2_E = 5; PCE = 32'h100; Imm_Ext_E = 32'h20; ALUControlE = 3'b000;
        #1;
        n_checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin n_fail++; $display("FAIL branch_taken: got %b %h expected 1 00000120", PCSrcE, PCTargetE); end
        RD2_E = 6;
        #1;
        n_checks++; if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken: got %b expected 0", PCSrcE); end
        RD2_E = 5; valid_e = 0;
        #1;
        n_checks++; if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL branch_invalid: got %b expected 0", PCSrcE); end
        valid_e = 1; flush_e = 1; RegWriteE = 1;
        #1;
        n_checks++; if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL branch_flushed: got %b expected 0", PCSrcE); end
        tick();
        n_checks++; if (valid_m !== 1'b0 || RegWriteM !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got v%b rw%b expected 0 0", valid_m, RegWriteM); end
        flush_e = 0; PCE = 32'hFFFFFFF0;
        #1;
        n_checks++; if (PCTargetE !== 32'h10) begin n_fail++; $display("FAIL target_wrap: got %h expected 00000010", PCTargetE); end
        idle_inputs();
        tick();
    endtask

    task automatic test_mul();
        int cyc, leaks;
        run_mul(32'd3, 32'hFFFFFFFB, 32'd3, cyc, leaks);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL mul_stall_len: got %0d expected 17", cyc); end
        n_checks++; if (leaks !== 0) begin n_fail++; $display("FAIL mul_bubbles: got %0d valid cycles expected 0", leaks); end
        n_checks++; if (ALU_ResultM !== 32'hFFFFFFF1 || valid_m !== 1'b1) begin n_fail++; $display("FAIL mul_result: got %h v%b expected fffffff1 v1", ALU_ResultM, valid_m); end
        n_checks++; if (RD_M !== 6'd7 || RegWriteM !== 1'b1) begin n_fail++; $display("FAIL mul_ctrl: got rd %0d rw %b expected 7 1", RD_M, RegWriteM); end
        idle_inputs();
        #1;
        n_checks++; if (stall_e !== 1'b0) begin n_fail++; $display("FAIL mul_no_restart: got %b expected 0", stall_e); end
        tick();
        run_mul(32'd6, 32'd7, 32'h100, cyc, leaks);
        n_checks++; if (ALU_ResultM !== 32'd42 || cyc !== 17) begin n_fail++; $display("FAIL mul_operand_hold: got %h cyc %0d expected 0000002a 17", ALU_ResultM, cyc); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, leaks;
        run_mul(32'h7FFFFFFF, 32'd2, 32'h7FFFFFFF, cyc, leaks);
        n_checks++; if (ALU_ResultM !== 32'hFFFFFFFE || cyc !== 17) begin n_fail++; $display("FAIL b2b_first: got %h cyc %0d expected fffffffe 17", ALU_ResultM, cyc); end
        run_mul(32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, cyc, leaks);
        n_checks++; if (ALU_ResultM !== 32'd16 || cyc !== 17 || leaks !== 0) begin n_fail++; $display("FAIL b2b_second: got %h cyc %0d leaks %0d expected 00000010 17 0", ALU_ResultM, cyc, leaks); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_mul();
        int n;
        idle_inputs();
        valid_e = 1; RegWriteE = 1; ALUControlE = 3'b001; RD1_E = 3; RD2_E = 5;
        #1;
        repeat (5) tick();
        flush_e = 1;
        #1;
        n_checks++; if (stall_e !== 1'b1) begin n_fail++; $display("FAIL flush_busy_stall: got %b expected 1", stall_e); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (stall_e !== 1'b0 || valid_m !== 1'b0) begin n_fail++; $display("FAIL flush_busy_abort: got stall %b v%b expected 0 0", stall_e, valid_m); end
        tick();
        n_checks++; if (valid_m !== 1'b0 || stall_e !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got v%b stall %b expected 0 0", valid_m, stall_e); end
        valid_e = 1; flush_e = 1; ALUControlE = 3'b001; RD1_E = 3; RD2_E = 5;
        #1;
        n_checks++; if (stall_e !== 1'b0) begin n_fail++; $display("FAIL flush_issue_stall: got %b expected 0", stall_e); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (stall_e !== 1'b0 || valid_m !== 1'b0) begin n_fail++; $display("FAIL flush_issue_nostart: got stall %b v%b expected 0 0", stall_e, valid_m); end
        valid_e = 1; RegWriteE = 1; ALUControlE = 3'b111; RD1_E = 32'h55; ALUSrcE = 1;
        tick();
        ALUSrcE = 0; ALUControlE = 3'b001; RD1_E = 3; RD2_E = 5;
        #1;
        n = 0;
        while (stall_e === 1'b1 && n < 100) begin n++; tick(); end
        flush_e = 1;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (valid_m !== 1'b0 || RegWriteM !== 1'b0 || ALU_ResultM !== 32'h55 || n !== 17) begin n_fail++; $display("FAIL flush_done: got v%b rw%b res %h n %0d expected 0 0 00000055 17", valid_m, RegWriteM, ALU_ResultM, n); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int cyc, leaks;
        idle_inputs();
        valid_e = 1; RegWriteE = 1; RD_E = 6'd3; PCPlus4E = 32'h44; RD1_E = 32'h1234; RD2_E = 32'h9; Imm_Ext_E = 0; ALUSrcE = 1;
        tick();
        ALUSrcE = 0; ALUControlE = 3'b001; RD1_E = 2; RD2_E = 9;
        #1;
        repeat (3) tick();
        rst = 0;
        #1;
        n_checks++; if (stall_e !== 1'b0 || PCSrcE !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got stall %b pcsrc %b expected 0 0", stall_e, PCSrcE); end
        n_checks++; if ({valid_m, RegWriteM, MemWriteM, ResultSrcM} !== 4'b0 || {ALU_ResultM, WriteDataM, PCPlus4M, RD_M} !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b %h %h %h %h expected zeros", {valid_m, RegWriteM}, ALU_ResultM, WriteDataM, PCPlus4M, RD_M); end
        idle_inputs();
        tick();
        rst = 1;
        tick();
        run_mul(32'd6, 32'd7, 32'd6, cyc, leaks);
        n_checks++; if (ALU_ResultM !== 32'd42 || valid_m !== 1'b1 || cyc !== 17) begin n_fail++; $display("FAIL rst_reissue: got %h v%b cyc %0d expected 0000002a v1 17", ALU_ResultM, valid_m, cyc); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forward();
        test_branch();
        test_mul();
        test_back_to_back();
        test_flush_mul();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
